// File: rtl/wb_pkg.sv
// rtl/wb_pkg.sv - shared entry type and sizing constants for the writeback arbiter
// Fallback for the "no result" tag when common_def.h has not already defined it.
`ifndef TAG_INVALID
`define TAG_INVALID 6'h3f
`endif

package wb_pkg;
  localparam int WB_FIFO_DEPTH = 2;
  localparam int WB_CNT_W      = 2;
  localparam int WB_N_SRC      = 3;
  localparam int WB_DATA_W     = 32;
  localparam int WB_TAG_W      = 6;

  typedef struct packed {
    logic [WB_DATA_W-1:0] result;
    logic [WB_TAG_W-1:0]  target;
  } wb_entry_t;
endpackage

// File: rtl/wb_src_fifo.sv
// rtl/wb_src_fifo.sv - two-entry per-producer result buffer (push, pop, head, count)
// Head always sits in slot 0; a pop shifts slot 1 down so the head is a plain register read.
module wb_src_fifo
  import wb_pkg::*;
#(
  parameter type entry_t = wb_entry_t
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                push,
  input  entry_t              push_entry,
  input  logic                pop,
  output entry_t              head,
  output logic [WB_CNT_W-1:0] count
);

  entry_t              mem_q [WB_FIFO_DEPTH];
  entry_t              mem_d [WB_FIFO_DEPTH];
  logic [WB_CNT_W-1:0] count_q;
  logic [WB_CNT_W-1:0] count_d;

  // Pop is applied before push so a simultaneous push lands behind the surviving entry.
  always_comb begin
    mem_d   = mem_q;
    count_d = count_q;
    if (pop) begin
      mem_d[0] = mem_q[1];
      count_d  = count_q - WB_CNT_W'(1);
    end
    if (push) begin
      mem_d[count_d[0]] = push_entry;
      count_d           = count_d + WB_CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign head  = mem_q[0];
  assign count = count_q;

endmodule

// File: rtl/wb_arbiter.sv
// rtl/wb_arbiter.sv - round-robin merge of N_SRC result producers onto one registered ROB writeback port
// Optional feature: define WB_ARBITER_PERF_EN to add per-source stall counters on port stall_cnt.
module wb_arbiter
  import wb_pkg::*;
#(
  parameter int N_SRC  = WB_N_SRC,
  parameter int DATA_W = WB_DATA_W,
  parameter int TAG_W  = WB_TAG_W
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [N_SRC-1:0][DATA_W-1:0]  in_result,
  input  logic [N_SRC-1:0][TAG_W-1:0]   in_target,
  output logic [N_SRC-1:0]              in_ready,
  output logic [DATA_W-1:0]             out_result,
  output logic [TAG_W-1:0]              out_target
`ifdef WB_ARBITER_PERF_EN
  ,
  output logic [N_SRC-1:0][15:0]        stall_cnt
`endif
);

  localparam int IDX_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;
  localparam logic [TAG_W-1:0] TAG_INV = TAG_W'(`TAG_INVALID);

  typedef struct packed {
    logic [DATA_W-1:0] result;
    logic [TAG_W-1:0]  target;
  } entry_t;

  logic [N_SRC-1:0]    offered;
  logic [N_SRC-1:0]    push;
  logic [N_SRC-1:0]    pop;
  logic [N_SRC-1:0]    nonempty;
  entry_t              push_entry [N_SRC];
  entry_t              head       [N_SRC];
  logic [WB_CNT_W-1:0] count      [N_SRC];

  logic                grant_valid;
  logic [IDX_W-1:0]    grant_idx;
  logic [IDX_W-1:0]    rr_ptr_q;
  logic [IDX_W-1:0]    rr_ptr_d;
  logic [DATA_W-1:0]   out_result_q;
  logic [DATA_W-1:0]   out_result_d;
  logic [TAG_W-1:0]    out_target_q;
  logic [TAG_W-1:0]    out_target_d;

  // Ready comes from the registered count alone, so a full FIFO drained this cycle still refuses.
  for (genvar i = 0; i < N_SRC; i++) begin : g_src
    assign offered[i]    = (in_target[i] != TAG_INV);
    assign in_ready[i]   = (count[i] < WB_CNT_W'(WB_FIFO_DEPTH));
    assign push[i]       = offered[i] && in_ready[i] && !rst;
    assign nonempty[i]   = (count[i] != '0);
    assign pop[i]        = grant_valid && (grant_idx == IDX_W'(i));
    assign push_entry[i] = entry_t'({in_result[i], in_target[i]});

    wb_src_fifo #(
      .entry_t (entry_t)
    ) u_fifo (
      .clk        (clk),
      .rst        (rst),
      .push       (push[i]),
      .push_entry (push_entry[i]),
      .pop        (pop[i]),
      .head       (head[i]),
      .count      (count[i])
    );
  end

  // Round-robin: first try sources at or above rr_ptr, then wrap to those below it.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    for (int i = 0; i < N_SRC; i++) begin
      if (!grant_valid && nonempty[i] && (i >= int'(rr_ptr_q))) begin
        grant_valid = 1'b1;
        grant_idx   = IDX_W'(i);
      end
    end
    for (int i = 0; i < N_SRC; i++) begin
      if (!grant_valid && nonempty[i]) begin
        grant_valid = 1'b1;
        grant_idx   = IDX_W'(i);
      end
    end
  end

  always_comb begin
    rr_ptr_d     = rr_ptr_q;
    out_result_d = out_result_q;
    out_target_d = TAG_INV;
    if (grant_valid) begin
      rr_ptr_d     = (grant_idx == IDX_W'(N_SRC - 1)) ? '0 : grant_idx + IDX_W'(1);
      out_result_d = head[grant_idx].result;
      out_target_d = head[grant_idx].target;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q     <= '0;
      out_result_q <= '0;
      out_target_q <= TAG_INV;
    end else begin
      rr_ptr_q     <= rr_ptr_d;
      out_result_q <= out_result_d;
      out_target_q <= out_target_d;
    end
  end

  assign out_result = out_result_q;
  assign out_target = out_target_q;

`ifdef WB_ARBITER_PERF_EN
  logic [N_SRC-1:0][15:0] stall_q;
  logic [N_SRC-1:0][15:0] stall_d;

  always_comb begin
    stall_d = stall_q;
    for (int i = 0; i < N_SRC; i++) begin
      if (offered[i] && !in_ready[i] && (stall_q[i] != 16'hffff)) begin
        stall_d[i] = stall_q[i] + 16'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q <= '0;
    end else begin
      stall_q <= stall_d;
    end
  end

  assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// tb/tb_wb_arbiter.sv - directed and random stimulus against a queue-based reference of the writeback arbiter
`ifndef TAG_INVALID
`define TAG_INVALID 6'h3f
`endif

module tb_wb_arbiter;
  localparam int N = 3;
  localparam logic [5:0] INV = `TAG_INVALID;

  typedef struct packed {
    logic [31:0] res;
    logic [5:0]  tag;
  } ent_t;

  logic              clk = 1'b0;
  logic              rst;
  logic [N-1:0][31:0] in_result;
  logic [N-1:0][5:0]  in_target;
  logic [N-1:0]      in_ready;
  logic [31:0]       out_result;
  logic [5:0]        out_target;
`ifdef WB_ARBITER_PERF_EN
  logic [N-1:0][15:0] stall_cnt;
`endif

  int checks = 0;
  int errors = 0;

  ent_t mq     [N][$];
  ent_t pend   [N][$];
  ent_t outlog [$];
  bit   busy     [N];
  int   busy_tag [N];
  int   stall_m  [N];
  int   rr;
  logic [5:0]  exp_tgt;
  logic [31:0] exp_res;

  wb_arbiter dut (
    .clk        (clk),
    .rst        (rst),
    .in_result  (in_result),
    .in_target  (in_target),
    .in_ready   (in_ready),
    .out_result (out_result),
    .out_target (out_target)
`ifdef WB_ARBITER_PERF_EN
    ,
    .stall_cnt  (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      if (pend[i].size() > 0) begin
        in_target[i] = pend[i][0].tag;
        in_result[i] = pend[i][0].res;
      end else begin
        in_target[i] = INV;
        in_result[i] = $urandom;
      end
    end
  endtask

  // Reference: per-source queues of depth 2, round-robin pointer, one registered output.
  task automatic model_edge();
    bit acc [N];
    int g;
    for (int i = 0; i < N; i++) begin
      acc[i] = !rst && (in_target[i] !== INV) && (mq[i].size() < 2);
      if (rst) stall_m[i] = 0;
      else if ((in_target[i] !== INV) && (mq[i].size() >= 2) && (stall_m[i] < 65535)) stall_m[i]++;
    end
    if (rst) begin
      for (int i = 0; i < N; i++) mq[i].delete();
      rr = 0;
      exp_tgt = INV;
      exp_res = '0;
    end else begin
      g = -1;
      for (int k = 0; k < N; k++) begin
        int idx;
        idx = (rr + k) % N;
        if (g < 0 && mq[idx].size() > 0) g = idx;
      end
      if (g >= 0) begin
        ent_t e;
        e = mq[g].pop_front();
        exp_tgt = e.tag;
        exp_res = e.res;
        rr = (g + 1) % N;
      end else begin
        exp_tgt = INV;
      end
      for (int i = 0; i < N; i++)
        if (acc[i]) mq[i].push_back(ent_t'({in_result[i], in_target[i]}));
    end
    for (int i = 0; i < N; i++) begin
      if (acc[i]) void'(pend[i].pop_front());
      if (busy[i] && pend[i].size() == 0) begin
        pend[i].push_back(ent_t'({32'($urandom), 6'(busy_tag[i])}));
        busy_tag[i]++;
      end
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < N; i++)
      chk($sformatf("in_ready[%0d]", i), 64'(in_ready[i]), 64'(mq[i].size() < 2));
    chk("out_target", 64'(out_target), 64'(exp_tgt));
    chk("out_result", 64'(out_result), 64'(exp_res));
    if (out_target !== INV) outlog.push_back(ent_t'({out_result, out_target}));
`ifdef WB_ARBITER_PERF_EN
    for (int i = 0; i < N; i++)
      chk($sformatf("stall_cnt[%0d]", i), 64'(stall_cnt[i]), 64'(stall_m[i]));
`endif
  endtask

  task automatic step();
    drive();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all();
  endtask

  task automatic clear_producers();
    for (int i = 0; i < N; i++) begin
      pend[i].delete();
      busy[i] = 1'b0;
    end
  endtask

  task automatic do_reset();
    clear_producers();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  initial begin
    int idx20;
    int last0;
    bit ok;
    bit saw_block;
    int cnt;
    logic [5:0] want;

    rst = 1'b1;
    in_target = {N{INV}};
    in_result = '0;
    clear_producers();
    step();
    step();
    rst = 1'b0;
    chk("reset_ready", 64'(in_ready), 64'(3'b111));
    chk("reset_out_target", 64'(out_target), 64'(INV));
    chk("reset_out_result", 64'(out_result), 64'(0));

    // Single entry on src1
    pend[1].push_back(ent_t'({32'hAA, 6'd5}));
    step();
    chk("single_before", 64'(out_target), 64'(INV));
    step();
    chk("single_tag", 64'(out_target), 64'(5));
    chk("single_res", 64'(out_result), 64'(32'hAA));
    step();
    chk("single_after", 64'(out_target), 64'(INV));
    chk("single_hold_res", 64'(out_result), 64'(32'hAA));

    // Contention from rr_ptr=0
    do_reset();
    for (int i = 0; i < N; i++) pend[i].push_back(ent_t'({32'(100 + i), 6'(i + 1)}));
    step();
    for (int i = 0; i < N; i++) begin
      step();
      chk($sformatf("contention_tag%0d", i), 64'(out_target), 64'(i + 1));
    end
    step();
    chk("contention_idle", 64'(out_target), 64'(INV));

    // Fairness: src0 streaming, src2 single tag 20
    do_reset();
    outlog.delete();
    busy[0] = 1'b1;
    busy_tag[0] = 10;
    pend[0].push_back(ent_t'({32'($urandom), 6'd10}));
    busy_tag[0] = 11;
    pend[2].push_back(ent_t'({32'h2020, 6'd20}));
    for (int c = 0; c < 8; c++) step();
    clear_producers();
    for (int c = 0; c < 6; c++) step();
    idx20 = -1;
    for (int k = 0; k < outlog.size(); k++) if (outlog[k].tag == 6'd20 && idx20 < 0) idx20 = k;
    chk("fair_tag20_seen", 64'(idx20 >= 0), 64'(1));
    chk("fair_within_2_grants", 64'(idx20 < 2), 64'(1));
    ok = 1'b1;
    last0 = -1;
    for (int k = 0; k < outlog.size(); k++) begin
      if (outlog[k].tag != 6'd20) begin
        if (int'(outlog[k].tag) <= last0) ok = 1'b0;
        last0 = int'(outlog[k].tag);
      end
    end
    chk("fair_src0_increasing", 64'(ok), 64'(1));

    // Backpressure on src0 with src1/src2 busy
    do_reset();
    outlog.delete();
    for (int t = 50; t < 54; t++) pend[0].push_back(ent_t'({32'($urandom), 6'(t)}));
    busy[1] = 1'b1; busy_tag[1] = 1;
    busy[2] = 1'b1; busy_tag[2] = 25;
    saw_block = 1'b0;
    for (int c = 0; c < 40 && pend[0].size() > 0; c++) begin
      step();
      if (pend[0].size() > 0 && in_ready[0] === 1'b0) saw_block = 1'b1;
    end
    chk("bp_all_accepted", 64'(pend[0].size()), 64'(0));
    clear_producers();
    for (int c = 0; c < 10; c++) step();
    chk("bp_ready_dropped", 64'(saw_block), 64'(1));
    cnt = 0;
    ok = 1'b1;
    for (int k = 0; k < outlog.size(); k++) begin
      if (outlog[k].tag >= 6'd50 && outlog[k].tag <= 6'd53) begin
        want = 6'(50 + cnt);
        if (outlog[k].tag != want) ok = 1'b0;
        cnt++;
      end
    end
    chk("bp_src0_count", 64'(cnt), 64'(4));
    chk("bp_src0_order", 64'(ok), 64'(1));

    // Reset mid-flight, with entries still offered during the reset cycle
    do_reset();
    busy[0] = 1'b1; busy_tag[0] = 1;
    busy[1] = 1'b1; busy_tag[1] = 21;
    busy[2] = 1'b1; busy_tag[2] = 41;
    for (int c = 0; c < 6; c++) step();
    for (int i = 0; i < N; i++) busy[i] = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    clear_producers();
    for (int c = 0; c < 5; c++) begin
      step();
      chk("midrst_out_idle", 64'(out_target), 64'(INV));
      chk("midrst_ready", 64'(in_ready), 64'(3'b111));
    end

    // Random traffic with occasional resets
    do_reset();
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++)
        if (pend[i].size() == 0 && $urandom_range(0, 2) != 0)
          pend[i].push_back(ent_t'({32'($urandom), 6'($urandom_range(0, 62))}));
      rst = ($urandom_range(0, 59) == 0);
      step();
    end
    rst = 1'b0;
    clear_producers();
    for (int c = 0; c < 8; c++) step();
    chk("final_idle", 64'(out_target), 64'(INV));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 Parameter N_SRC, 3, number of result producers (ALU, forwarder, LSU) sharing the ROB writeback port.
REQ-002 Parameter DATA_W, 32, result width.
REQ-003 Parameter TAG_W, 6, ROB tag width; the value `TAG_INVALID from common_def.h marks "no result".
REQ-004 clk  input  1  single clock; all state updates on posedge clk.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 in_result  input  N_SRC x DATA_W  per-source result.
REQ-007 in_target  input  N_SRC x TAG_W  per-source ROB tag; an entry is offered when the tag is not `TAG_INVALID.
REQ-008 in_ready  output  N_SRC  per-source accept; an offered entry is taken at a posedge when in_ready is 1; the producer holds the entry while in_ready is 0.
REQ-009 out_result  output  DATA_W  registered result to ROB.
REQ-010 out_target  output  TAG_W  registered tag to ROB; `TAG_INVALID means idle; the ROB always accepts.

Function
REQ-011 Each source SHALL own a 2-entry FIFO; in_ready[i] = (count[i] < 2), from registered count only, with no path from in_target or the grant.
REQ-012 A full FIFO dequeued in a cycle SHALL still show in_ready=0 in that cycle (no pass-through).
REQ-013 Simultaneous enqueue and dequeue on the same FIFO SHALL leave count unchanged and keep order.
REQ-014 Each cycle the arbiter SHALL grant at most one non-empty FIFO, searching round-robin from rr_ptr upward, mod N_SRC.
REQ-015 On a grant to source g, rr_ptr SHALL become (g+1) mod N_SRC; with no grant rr_ptr holds.
REQ-016 The granted FIFO head SHALL be popped and registered onto out_result/out_target at the same posedge; with no grant out_target SHALL be `TAG_INVALID and out_result holds.
REQ-017 Latency: an entry accepted at posedge k SHALL appear on out no earlier than the cycle after posedge k+1; with an empty arbiter it appears exactly then.
REQ-018 Per-source order SHALL be preserved; entries are never dropped or duplicated.
REQ-019 Offered entries with in_target == `TAG_INVALID SHALL never be enqueued.

Reset
REQ-020 With rst high at a posedge: all FIFO counts 0, rr_ptr 0, out_target `TAG_INVALID, out_result 0, and in_ready all 1 from the next cycle.
REQ-021 Reset mid-operation SHALL discard all buffered entries, and no stale tag SHALL appear on out afterwards.
REQ-022 An input offered in the reset cycle SHALL NOT be enqueued.

Configuration
REQ-023 Macro WB_ARBITER_PERF_EN, when defined, SHALL add output stall_cnt (N_SRC x 16): per-source saturating count of cycles with an offered entry and in_ready=0, cleared by rst.
REQ-024 Without WB_ARBITER_PERF_EN, the stall_cnt port and its counters SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-025 Package wb_pkg SHALL hold wb_entry_t {result, target}, WB_FIFO_DEPTH=2 and the N_SRC default; common_def.h supplies `TAG_INVALID.
REQ-026 Per-source buffering SHALL be sub-module wb_src_fifo (push, pop, head, count), instantiated N_SRC times; arbitration and the output register live in wb_arbiter.

Verification
REQ-027 Single entry: src1 offers tag 5, result 0xAA at posedge 1, then idle -> out_target=5, out_result=0xAA in the cycle after posedge 2 only; `TAG_INVALID otherwise.
REQ-028 Contention: all 3 sources offer one entry each at posedge 1 (tags 1, 2, 3), rr_ptr=0 -> out tags 1, 2, 3 on consecutive cycles; rr_ptr ends at 0.
REQ-029 Fairness: src0 offers continuously (tags 10, 11, ...) while src2 offers tag 20 -> tag 20 appears within 2 grants; src0 order is strictly increasing.
REQ-030 Backpressure: src0 offers 4 entries back-to-back while src1 and src2 are kept busy -> in_ready[0] drops after 2 accepts; all 4 tags emerge in order, none lost.
REQ-031 Reset mid-flight: 2 entries buffered in each FIFO, rst pulsed for 1 cycle -> out_target stays `TAG_INVALID afterwards and in_ready=3'b111.
REQ-032 With WB_ARBITER_PERF_EN: src0 held blocked for 5 cycles -> stall_cnt[0]=5; counters saturate at 0xFFFF.
